// File: rtl/dtc_cmd_tx.sv
// dtc_cmd_tx: byte-stream command transmitter toward the DTC serializer.
// Serves readout, abort and fast single-byte commands plus 9-byte
// read/write frames, each followed by an idle 8'h00 byte.
// Optional build macro: DTC_FASTCMD_EN enables the fast-command path;
// without it FastCmd/FastCmdCode are ignored and FastCmdAck is tied low.
//
// state      | meaning
// IDLE       | output 00, pick next request by priority rdo/abort/fast/rw
// SEND_RDO   | emit RDOCMD_CODE
// SEND_ABORT | emit ABORTCMD_CODE
// SEND_FAST  | emit FastCmdCode (only with DTC_FASTCMD_EN)
// WR0        | emit RWCMD_CODE, latch cmd_addr/cmd_data into shadows
// WR1..WR8   | emit shadow address then data, MSB byte first
// TAIL       | emit 00 trailer, back to IDLE
module dtc_cmd_tx #(
  parameter logic [7:0] RWCMD_CODE    = 8'hE1,
  parameter logic [7:0] RDOCMD_CODE   = 8'hE2,
  parameter logic [7:0] ABORTCMD_CODE = 8'hEA
) (
  input  logic        bitclkdiv,
  input  logic        reset,
  input  logic        rdocmd,
  input  logic        abortcmd,
  input  logic        FastCmd,
  input  logic [7:0]  FastCmdCode,
  output logic        FastCmdAck,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        cmd_dv,
  output logic        cmd_dv_ack,
  output logic [7:0]  dtc_pdin
);

  typedef enum logic [13:0] {
    IDLE       = 14'h0001,
    SEND_RDO   = 14'h0002,
    SEND_ABORT = 14'h0004,
`ifdef DTC_FASTCMD_EN
    SEND_FAST  = 14'h0008,
`endif
    WR0        = 14'h0010,
    WR1        = 14'h0020,
    WR2        = 14'h0040,
    WR3        = 14'h0080,
    WR4        = 14'h0100,
    WR5        = 14'h0200,
    WR6        = 14'h0400,
    WR7        = 14'h0800,
    WR8        = 14'h1000,
    TAIL       = 14'h2000
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pdin_d;
  logic [31:0] addr_sh, data_sh;
  logic        capture;
  logic        edge_arm;
  logic        rdo_prev, abort_prev;
  logic        rdo_pend, abort_pend;
  logic        rdo_ack, abort_ack;
  logic        rdo_ack_d, abort_ack_d, dv_ack_d;
  logic        rdo_edge, abort_edge;

  // Edge history only counts after one post-reset sample, so a level held
  // high through reset is not mistaken for a new request.
  assign rdo_edge   = edge_arm & rdocmd   & ~rdo_prev;
  assign abort_edge = edge_arm & abortcmd & ~abort_prev;

`ifdef DTC_FASTCMD_EN
  logic fast_prev, fast_pend, fast_ack, fast_ack_d, fast_edge;
  assign fast_edge  = edge_arm & FastCmd & ~fast_prev;
  assign FastCmdAck = fast_ack;

  // Fast-command edge history and pending flag; a new edge beats the ack clear.
  always_ff @(posedge bitclkdiv or posedge reset) begin
    if (reset) begin
      fast_prev <= 1'b0;
      fast_pend <= 1'b0;
      fast_ack  <= 1'b0;
    end else begin
      fast_prev <= FastCmd;
      fast_pend <= fast_edge | (fast_pend & ~fast_ack);
      fast_ack  <= fast_ack_d;
    end
  end
`else
  logic unused_fast;
  assign unused_fast = ^{FastCmd, FastCmdCode};
  assign FastCmdAck  = 1'b0;
`endif

  // Readout/abort edge history and pending flags; a new edge beats the ack clear.
  always_ff @(posedge bitclkdiv or posedge reset) begin
    if (reset) begin
      edge_arm   <= 1'b0;
      rdo_prev   <= 1'b0;
      abort_prev <= 1'b0;
      rdo_pend   <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      edge_arm   <= 1'b1;
      rdo_prev   <= rdocmd;
      abort_prev <= abortcmd;
      rdo_pend   <= rdo_edge   | (rdo_pend   & ~rdo_ack);
      abort_pend <= abort_edge | (abort_pend & ~abort_ack);
    end
  end

  // State, output byte, ack pulses and frame shadows.
  always_ff @(posedge bitclkdiv or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dtc_pdin   <= 8'h00;
      rdo_ack    <= 1'b0;
      abort_ack  <= 1'b0;
      cmd_dv_ack <= 1'b0;
      addr_sh    <= 32'h0;
      data_sh    <= 32'h0;
    end else begin
      state_q    <= state_d;
      dtc_pdin   <= pdin_d;
      rdo_ack    <= rdo_ack_d;
      abort_ack  <= abort_ack_d;
      cmd_dv_ack <= dv_ack_d;
      if (capture) begin
        addr_sh <= cmd_addr;
        data_sh <= cmd_data;
      end
    end
  end

  // Next state, next output byte and ack requests.
  always_comb begin
    state_d     = state_q;
    pdin_d      = 8'h00;
    capture     = 1'b0;
    rdo_ack_d   = 1'b0;
    abort_ack_d = 1'b0;
    dv_ack_d    = 1'b0;
`ifdef DTC_FASTCMD_EN
    fast_ack_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rdo_pend)        state_d = SEND_RDO;
        else if (abort_pend) state_d = SEND_ABORT;
`ifdef DTC_FASTCMD_EN
        else if (fast_pend)  state_d = SEND_FAST;
`endif
        else if (cmd_dv)     state_d = WR0;
      end
      SEND_RDO:   begin pdin_d = RDOCMD_CODE;   rdo_ack_d   = 1'b1; state_d = TAIL; end
      SEND_ABORT: begin pdin_d = ABORTCMD_CODE; abort_ack_d = 1'b1; state_d = TAIL; end
`ifdef DTC_FASTCMD_EN
      SEND_FAST:  begin pdin_d = FastCmdCode;   fast_ack_d  = 1'b1; state_d = TAIL; end
`endif
      WR0: begin
        pdin_d   = RWCMD_CODE;
        capture  = 1'b1;
        dv_ack_d = 1'b1;
        state_d  = WR1;
      end
      WR1:  begin pdin_d = addr_sh[31:24]; state_d = WR2;  end
      WR2:  begin pdin_d = addr_sh[23:16]; state_d = WR3;  end
      WR3:  begin pdin_d = addr_sh[15:8];  state_d = WR4;  end
      WR4:  begin pdin_d = addr_sh[7:0];   state_d = WR5;  end
      WR5:  begin pdin_d = data_sh[31:24]; state_d = WR6;  end
      WR6:  begin pdin_d = data_sh[23:16]; state_d = WR7;  end
      WR7:  begin pdin_d = data_sh[15:8];  state_d = WR8;  end
      WR8:  begin pdin_d = data_sh[7:0];   state_d = TAIL; end
      TAIL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dtc_cmd_tx.sv
// Directed bench for dtc_cmd_tx with hand-computed byte streams.
// cap[i] holds dtc_pdin sampled 1 time unit after the (i+1)-th rising edge
// following stimulus launch.
module tb_dtc_cmd_tx;
  logic        bitclkdiv = 1'b0;
  logic        reset = 1'b1;
  logic        rdocmd = 1'b0, abortcmd = 1'b0, FastCmd = 1'b0, cmd_dv = 1'b0;
  logic [7:0]  FastCmdCode = 8'h00;
  logic [31:0] cmd_addr = 32'h0, cmd_data = 32'h0;
  logic        FastCmdAck, cmd_dv_ack;
  logic [7:0]  dtc_pdin;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] cap [0:15];
  logic [7:0] exp_b [0:15];

  dtc_cmd_tx dut (
    .bitclkdiv(bitclkdiv), .reset(reset), .rdocmd(rdocmd), .abortcmd(abortcmd),
    .FastCmd(FastCmd), .FastCmdCode(FastCmdCode), .FastCmdAck(FastCmdAck),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_dv(cmd_dv),
    .cmd_dv_ack(cmd_dv_ack), .dtc_pdin(dtc_pdin)
  );

  always #5 bitclkdiv = ~bitclkdiv;

  task automatic cyc();
    @(posedge bitclkdiv);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (dtc_pdin !== 8'h00) begin n_bad++; $display("FAIL reset_pdin got=%h exp=00", dtc_pdin); end
    n_cmp++; if (cmd_dv_ack !== 1'b0) begin n_bad++; $display("FAIL reset_dv_ack got=%b exp=0", cmd_dv_ack); end
    n_cmp++; if (FastCmdAck !== 1'b0) begin n_bad++; $display("FAIL reset_fast_ack got=%b exp=0", FastCmdAck); end
    cyc(); cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_cmp++; if (dtc_pdin !== 8'h00) begin n_bad++; $display("FAIL idle_pdin[%0d] got=%h exp=00", i, dtc_pdin); end
    end
  endtask

  task automatic test_rdo();
    int n_ack = 0;
    int n_other = 0;
    rdocmd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      cap[i] = dtc_pdin;
      if (dut.rdo_ack === 1'b1) n_ack++;
      if (cmd_dv_ack !== 1'b0 || FastCmdAck !== 1'b0) n_other++;
      if (i == 0) rdocmd = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      exp_b[i] = (i == 2) ? 8'hE2 : 8'h00;
      n_cmp++; if (cap[i] !== exp_b[i]) begin n_bad++; $display("FAIL rdo_byte[%0d] got=%h exp=%h", i, cap[i], exp_b[i]); end
    end
    n_cmp++; if (n_ack != 1) begin n_bad++; $display("FAIL rdo_ack_count got=%0d exp=1", n_ack); end
    n_cmp++; if (n_other != 0) begin n_bad++; $display("FAIL rdo_other_acks got=%0d exp=0", n_other); end
  endtask

  task automatic test_read_write();
    int n_ack = 0;
    int ack_at = -1;
    exp_b = '{8'h00, 8'hE1, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
              8'hDE, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    cmd_addr = 32'h12345678;
    cmd_data = 32'h9ABCDEF0;
    cmd_dv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      cap[i] = dtc_pdin;
      if (cmd_dv_ack === 1'b1) begin
        n_ack++;
        ack_at = i;
        cmd_dv = 1'b0;
        cmd_addr = 32'hFFFF_FFFF;
        cmd_data = 32'h0000_0000;
      end
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (cap[i] !== exp_b[i]) begin n_bad++; $display("FAIL rw_byte[%0d] got=%h exp=%h", i, cap[i], exp_b[i]); end
    end
    n_cmp++; if (n_ack != 1) begin n_bad++; $display("FAIL rw_ack_count got=%0d exp=1", n_ack); end
    n_cmp++; if (ack_at != 1) begin n_bad++; $display("FAIL rw_ack_cycle got=%0d exp=1", ack_at); end
  endtask

  task automatic test_simultaneous();
    int n_fack = 0;
    int exp_fack;
    FastCmdCode = 8'hC3;
    rdocmd = 1'b1; abortcmd = 1'b1; FastCmd = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cyc();
      cap[i] = dtc_pdin;
      if (FastCmdAck === 1'b1) n_fack++;
      if (i == 0) begin rdocmd = 1'b0; abortcmd = 1'b0; FastCmd = 1'b0; end
    end
    for (int i = 0; i < 14; i++) exp_b[i] = 8'h00;
    exp_b[2] = 8'hE2;
    exp_b[5] = 8'hEA;
`ifdef DTC_FASTCMD_EN
    exp_b[8] = 8'hC3;
    exp_fack = 1;
`else
    exp_fack = 0;
`endif
    for (int i = 0; i < 14; i++) begin
      n_cmp++; if (cap[i] !== exp_b[i]) begin n_bad++; $display("FAIL simul_byte[%0d] got=%h exp=%h", i, cap[i], exp_b[i]); end
    end
    n_cmp++; if (n_fack != exp_fack) begin n_bad++; $display("FAIL simul_fast_ack got=%0d exp=%0d", n_fack, exp_fack); end
  endtask

  task automatic test_abort_mid_frame();
    exp_b = '{8'h00, 8'hE1, 8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5,
              8'h06, 8'h17, 8'h00, 8'h00, 8'hEA, 8'h00, 8'h00, 8'h00};
    cmd_addr = 32'hA0B1C2D3;
    cmd_data = 32'hE4F50617;
    cmd_dv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      cap[i] = dtc_pdin;
      if (cmd_dv_ack === 1'b1) cmd_dv = 1'b0;
      if (i == 3) abortcmd = 1'b1;
      if (i == 4) abortcmd = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (cap[i] !== exp_b[i]) begin n_bad++; $display("FAIL abort_mid_byte[%0d] got=%h exp=%h", i, cap[i], exp_b[i]); end
    end
  endtask

  task automatic test_merge();
    int n_e2 = 0;
    rdocmd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      cap[i] = dtc_pdin;
      if (dtc_pdin === 8'hE2) n_e2++;
      if (i == 0) rdocmd = 1'b0;
      if (i == 1) rdocmd = 1'b1;
      if (i == 2) rdocmd = 1'b0;
    end
    n_cmp++; if (n_e2 != 1) begin n_bad++; $display("FAIL merge_e2_count got=%0d exp=1", n_e2); end
    n_cmp++; if (cap[2] !== 8'hE2) begin n_bad++; $display("FAIL merge_e2_pos got=%h exp=e2", cap[2]); end
  endtask

  task automatic test_reset_mid_frame();
    int n_nz = 0;
    int n_ack = 0;
    cmd_addr = 32'h12345678;
    cmd_data = 32'h9ABCDEF0;
    cmd_dv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      cap[i] = dtc_pdin;
      if (cmd_dv_ack === 1'b1) cmd_dv = 1'b0;
    end
    n_cmp++; if (cap[4] !== 8'h56) begin n_bad++; $display("FAIL rstmid_pre got=%h exp=56", cap[4]); end
    #2;
    reset = 1'b1;
    cmd_dv = 1'b0;
    #1;
    n_cmp++; if (dtc_pdin !== 8'h00) begin n_bad++; $display("FAIL rstmid_pdin got=%h exp=00", dtc_pdin); end
    n_cmp++; if (cmd_dv_ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_ack got=%b exp=0", cmd_dv_ack); end
    rdocmd = 1'b1;
    cyc(); cyc(); cyc();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (dtc_pdin !== 8'h00) n_nz++;
      if (cmd_dv_ack !== 1'b0 || FastCmdAck !== 1'b0 || dut.rdo_ack !== 1'b0) n_ack++;
    end
    rdocmd = 1'b0;
    n_cmp++; if (n_nz != 0) begin n_bad++; $display("FAIL rstmid_after_bytes got=%0d exp=0", n_nz); end
    n_cmp++; if (n_ack != 0) begin n_bad++; $display("FAIL rstmid_after_acks got=%0d exp=0", n_ack); end
    cyc();
  endtask

  task automatic test_fast();
    int n_fack = 0;
    FastCmdCode = 8'h5A;
    FastCmd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      cap[i] = dtc_pdin;
      if (FastCmdAck === 1'b1) n_fack++;
      if (i == 0) FastCmd = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
`ifdef DTC_FASTCMD_EN
      exp_b[i] = (i == 2) ? 8'h5A : 8'h00;
`else
      exp_b[i] = 8'h00;
`endif
      n_cmp++; if (cap[i] !== exp_b[i]) begin n_bad++; $display("FAIL fast_byte[%0d] got=%h exp=%h", i, cap[i], exp_b[i]); end
    end
`ifdef DTC_FASTCMD_EN
    n_cmp++; if (n_fack != 1) begin n_bad++; $display("FAIL fast_ack_count got=%0d exp=1", n_fack); end
`else
    n_cmp++; if (n_fack != 0) begin n_bad++; $display("FAIL fast_ack_count got=%0d exp=0", n_fack); end
`endif
  endtask

  initial begin
    test_reset();
    test_rdo();
    test_read_write();
    test_simultaneous();
    test_abort_mid_frame();
    test_merge();
    test_reset_mid_frame();
    test_fast();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dtc_cmd_tx.md
DTC_CMD_TX -- requirements
Module: dtc_cmd_tx

Interface
REQ-001 Parameter RWCMD_CODE, default 8'hE1: header byte of a read/write command frame.
REQ-002 Parameter RDOCMD_CODE, default 8'hE2: readout command byte.
REQ-003 Parameter ABORTCMD_CODE, default 8'hEA: abort command byte.
REQ-004 bitclkdiv  in  1: the single clock; all logic on rising edge.
REQ-005 reset  in  1: asynchronous, active-high reset.
REQ-006 rdocmd  in  1: readout request; a rising edge is one request.
REQ-007 abortcmd  in  1: abort request; a rising edge is one request.
REQ-008 FastCmd  in  1: fast-command request; a rising edge is one request.
REQ-009 FastCmdCode  in  8: byte sent for a fast command; sampled in the SEND_FAST cycle.
REQ-010 FastCmdAck  out  1: one-cycle pulse when the fast command is sent.
REQ-011 cmd_addr  in  32: command address.
REQ-012 cmd_data  in  32: command data.
REQ-013 cmd_dv  in  1: level request for a read/write frame; held until cmd_dv_ack.
REQ-014 cmd_dv_ack  out  1: one-cycle pulse acknowledging cmd_dv.
REQ-015 dtc_pdin  out  8: registered byte stream to the downstream serializer; 8'h00 = idle.

Function
REQ-016 Each of rdocmd, abortcmd and FastCmd shall have a pending flag, set on an input rising edge (previous sample 0, current sample 1) and cleared by its own ack pulse; when set and clear coincide, set wins.
REQ-017 Repeated edges while a flag is already set shall merge into one request.
REQ-018 The FSM shall be one-hot, with states IDLE, SEND_RDO, SEND_ABORT, SEND_FAST, WR0..WR8 and TAIL; illegal encodings shall recover to IDLE.
REQ-019 In IDLE, dtc_pdin = 8'h00; next state by priority: rdo flag -> SEND_RDO; else abort flag -> SEND_ABORT; else fast flag -> SEND_FAST; else cmd_dv -> WR0; else stay in IDLE.
REQ-020 SEND_RDO, SEND_ABORT and SEND_FAST shall register RDOCMD_CODE, ABORTCMD_CODE and FastCmdCode respectively onto dtc_pdin, then go to TAIL.
REQ-021 WR0 shall drive RWCMD_CODE and capture cmd_addr/cmd_data into shadow registers; WR1..WR8 shall drive addr[31:24], [23:16], [15:8], [7:0], then data[31:24], [23:16], [15:8], [7:0] from the shadows; WR8 then goes to TAIL.
REQ-022 TAIL shall drive 8'h00 and return to IDLE, giving at least one idle byte between frames.
REQ-023 Each ack shall be a registered pulse, high exactly one cycle, on the clock after its SEND state (cmd_dv_ack after WR0); the flag is clear before the next IDLE evaluation.
REQ-024 Frame lengths: a single command is 2 cycles (code + 00); read/write is 10 cycles (9 bytes + 00).
REQ-025 A request arriving mid-frame shall stay pending and be served in the next IDLE by priority.
REQ-026 The requester may change cmd_addr/cmd_data after cmd_dv_ack without corrupting the frame in flight.

Reset
REQ-027 reset shall act immediately: state=IDLE; dtc_pdin=8'h00; all acks=0; all pending flags and edge-detect history=0; shadows=0.
REQ-028 Reset mid-frame shall abort the frame with no further bytes; an input held high through reset shall not count as an edge after release.

Configuration
REQ-029 Macro DTC_FASTCMD_EN: when defined, the fast-command path (REQ-016, REQ-019, REQ-020) exists; when undefined, FastCmd and FastCmdCode are ignored, SEND_FAST is absent and FastCmdAck is tied 0.

Verification
REQ-030 One-cycle rdocmd pulse from idle -> dtc_pdin E2 for one cycle then 00; a single FastCmdAck-style ack pulse (rdo internal); with RDOCMD_CODE default.
REQ-031 cmd_dv=1, addr=32'h12345678, data=32'h9ABCDEF0 -> bytes E1,12,34,56,78,9A,BC,DE,F0,00; one cmd_dv_ack pulse; changing addr after ack has no effect.
REQ-032 rdocmd, abortcmd and FastCmd (code 8'hC3) rising in the same cycle -> E2,00,EA,00,C3,00 in that order; FastCmdAck pulses once.
REQ-033 abortcmd pulse during a read/write frame -> frame completes intact, then EA,00.
REQ-034 reset asserted during WR4 -> dtc_pdin=00 immediately, no ack, IDLE after release; DTC_FASTCMD_EN undefined -> FastCmd pulse gives no output and FastCmdAck stays 0.
